// File: rtl/panda_risc_v_alu_op_gen.sv
// Execute-stage ALU operand generator.
// RV32I decode into ALU op/operands behind a registered 2-entry skid buffer.
module panda_risc_v_alu_op_gen #(
    parameter string en_illegal_check = "true"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_inst,
    input  logic [31:0] s_pc,
    input  logic [31:0] s_rs1_v,
    input  logic [31:0] s_rs2_v,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_op_mode,
    output logic [31:0] m_op1,
    output logic [31:0] m_op2,
    output logic [31:0] m_pc,
    output logic [4:0]  m_rd,
    output logic        m_is_brc,
    output logic        m_is_ls,
    output logic        m_illegal
);

    localparam logic CHK = (en_illegal_check == "true");

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_EQU  = 4'd2;
    localparam logic [3:0] ALU_NEQU = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SGE  = 4'd5;
    localparam logic [3:0] ALU_ULT  = 4'd6;
    localparam logic [3:0] ALU_UGE  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_AND  = 4'd10;
    localparam logic [3:0] ALU_SLL  = 4'd11;
    localparam logic [3:0] ALU_SRL  = 4'd12;
    localparam logic [3:0] ALU_SRA  = 4'd13;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        brc;
        logic        ls;
        logic        ill;
    } beat_t;

    // funct3 -> ALU op for OP/OP-IMM; alt selects SUB/SRA
    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        case (f3)
            3'd0:    r = alt ? ALU_SUB : ALU_ADD;
            3'd1:    r = ALU_SLL;
            3'd2:    r = ALU_SLT;
            3'd3:    r = ALU_ULT;
            3'd4:    r = ALU_XOR;
            3'd5:    r = alt ? ALU_SRA : ALU_SRL;
            3'd6:    r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic        w_shift;
    beat_t       w_beat;

    assign w_opc   = s_inst[6:0];
    assign w_f3    = s_inst[14:12];
    assign w_f7    = s_inst[31:25];
    assign w_imm_i = {{20{s_inst[31]}}, s_inst[31:20]};
    assign w_imm_s = {{20{s_inst[31]}}, s_inst[31:25], s_inst[11:7]};
    assign w_imm_u = {s_inst[31:12], 12'd0};
    assign w_shift = (w_f3 == 3'd1) || (w_f3 == 3'd5);

    // Combinational decode of the incoming instruction
    always_comb begin
        w_beat     = '0;
        w_beat.op  = ALU_ADD;
        w_beat.pc  = s_pc;
        w_beat.rd  = s_inst[11:7];
        unique case (w_opc)
            OPC_OP: begin
                w_beat.op1 = s_rs1_v;
                w_beat.op2 = s_rs2_v;
                w_beat.op  = f3_alu(w_f3, s_inst[30]);
                w_beat.ill = CHK && !((w_f7 == 7'h00) ||
                    ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
            end
            OPC_OPIMM: begin
                w_beat.op1 = s_rs1_v;
                w_beat.op2 = w_shift ? {27'd0, s_inst[24:20]} : w_imm_i;
                w_beat.op  = f3_alu(w_f3, w_shift & s_inst[30]);
                w_beat.ill = CHK && w_shift && !((w_f7 == 7'h00) ||
                    ((w_f3 == 3'd5) && (w_f7 == 7'h20)));
            end
            OPC_LUI: begin
                w_beat.op2 = w_imm_u;
            end
            OPC_AUIPC: begin
                w_beat.op1 = s_pc;
                w_beat.op2 = w_imm_u;
            end
            OPC_JAL: begin
                w_beat.op1 = s_pc;
                w_beat.op2 = 32'd4;
            end
            OPC_JALR: begin
                w_beat.op1 = s_pc;
                w_beat.op2 = 32'd4;
                w_beat.ill = CHK && (w_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_beat.rd  = 5'd0;
                w_beat.brc = 1'b1;
                w_beat.op1 = s_rs1_v;
                w_beat.op2 = s_rs2_v;
                case (w_f3)
                    3'd0:    w_beat.op = ALU_EQU;
                    3'd1:    w_beat.op = ALU_NEQU;
                    3'd4:    w_beat.op = ALU_SLT;
                    3'd5:    w_beat.op = ALU_SGE;
                    3'd6:    w_beat.op = ALU_ULT;
                    3'd7:    w_beat.op = ALU_UGE;
                    default: begin
                        w_beat.op  = w_f3[0] ? ALU_NEQU : ALU_EQU;
                        w_beat.ill = CHK;
                    end
                endcase
            end
            OPC_LOAD: begin
                w_beat.ls  = 1'b1;
                w_beat.op1 = s_rs1_v;
                w_beat.op2 = w_imm_i;
            end
            OPC_STORE: begin
                w_beat.rd  = 5'd0;
                w_beat.ls  = 1'b1;
                w_beat.op1 = s_rs1_v;
                w_beat.op2 = w_imm_s;
            end
            default: begin
                w_beat.ill = 1'b1;
            end
        endcase
        if (w_beat.ill) begin
            w_beat.op  = ALU_ADD;
            w_beat.op1 = '0;
            w_beat.op2 = '0;
            w_beat.brc = 1'b0;
            w_beat.ls  = 1'b0;
        end
    end

    beat_t r_main;
    beat_t r_skid;
    logic  r_m_valid;
    logic  r_skid_full;
    logic  r_s_ready;

    beat_t w_main_nxt;
    beat_t w_skid_nxt;
    logic  w_m_valid_nxt;
    logic  w_skid_full_nxt;
    logic  w_acc;

    assign w_acc = s_valid & r_s_ready;

    // Skid-buffer next state: main refills from skid first, else from input
    always_comb begin
        w_main_nxt      = r_main;
        w_skid_nxt      = r_skid;
        w_m_valid_nxt   = r_m_valid;
        w_skid_full_nxt = r_skid_full;
        if (flush) begin
            w_m_valid_nxt   = 1'b0;
            w_skid_full_nxt = 1'b0;
        end else if (!r_m_valid || m_ready) begin
            if (r_skid_full) begin
                w_main_nxt      = r_skid;
                w_m_valid_nxt   = 1'b1;
                w_skid_full_nxt = 1'b0;
            end else if (w_acc) begin
                w_main_nxt    = w_beat;
                w_m_valid_nxt = 1'b1;
            end else begin
                w_m_valid_nxt = 1'b0;
            end
        end else if (w_acc) begin
            w_skid_nxt      = w_beat;
            w_skid_full_nxt = 1'b1;
        end
    end

    // State registers; ready is registered from next skid occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main      <= '0;
            r_skid      <= '0;
            r_m_valid   <= 1'b0;
            r_skid_full <= 1'b0;
            r_s_ready   <= 1'b1;
        end else begin
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_skid_full <= w_skid_full_nxt;
            r_s_ready   <= !w_skid_full_nxt;
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign m_op_mode = r_main.op;
    assign m_op1     = r_main.op1;
    assign m_op2     = r_main.op2;
    assign m_pc      = r_main.pc;
    assign m_rd      = r_main.rd;
    assign m_is_brc  = r_main.brc;
    assign m_is_ls   = r_main.ls;
    assign m_illegal = r_main.ill;

endmodule

// File: tb/tb_panda_risc_v_alu_op_gen.sv
// Bench for panda_risc_v_alu_op_gen.
// Directed literal cases plus random traffic against a 2-deep FIFO model.
module tb_panda_risc_v_alu_op_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_inst = '0;
    logic [31:0] s_pc = '0;
    logic [31:0] s_rs1_v = '0;
    logic [31:0] s_rs2_v = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  m_op_mode;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    logic        m_is_brc;
    logic        m_is_ls;
    logic        m_illegal;

    panda_risc_v_alu_op_gen dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_inst(s_inst), .s_pc(s_pc),
        .s_rs1_v(s_rs1_v), .s_rs2_v(s_rs2_v),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_op_mode(m_op_mode), .m_op1(m_op1), .m_op2(m_op2),
        .m_pc(m_pc), .m_rd(m_rd), .m_is_brc(m_is_brc),
        .m_is_ls(m_is_ls), .m_illegal(m_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        int unsigned rd;
        bit          brc;
        bit          ls;
        bit          ill;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the RV32I field rules
    function automatic exp_t ref_dec(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
        int unsigned alu_map[8] = '{0, 11, 4, 6, 8, 12, 9, 10};
        int unsigned brc_map[8] = '{2, 3, 0, 0, 4, 5, 6, 7};
        exp_t e;
        int unsigned opc = inst[6:0];
        int unsigned f3 = inst[14:12];
        int unsigned f7 = inst[31:25];
        logic [31:0] imm_i = 32'(signed'(inst[31:20]));
        logic [31:0] imm_s = 32'(signed'({inst[31:25], inst[11:7]}));
        logic [31:0] imm_u = inst & 32'hFFFFF000;
        e = '{op: 0, op1: 0, op2: 0, pc: pc, rd: inst[11:7], brc: 0, ls: 0, ill: 0};
        case (opc)
            'h33: begin
                e.op1 = a; e.op2 = b; e.op = alu_map[f3];
                if (f7 == 'h20 && f3 == 0) e.op = 1;
                if (f7 == 'h20 && f3 == 5) e.op = 13;
                if (!(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)))) e.ill = 1;
            end
            'h13: begin
                e.op1 = a; e.op = alu_map[f3];
                if (f3 == 1 || f3 == 5) begin
                    e.op2 = inst[24:20];
                    if (f3 == 5 && f7 == 'h20) e.op = 13;
                    if (!(f7 == 0 || (f3 == 5 && f7 == 'h20))) e.ill = 1;
                end else e.op2 = imm_i;
            end
            'h37: e.op2 = imm_u;
            'h17: begin e.op1 = pc; e.op2 = imm_u; end
            'h6F: begin e.op1 = pc; e.op2 = 4; end
            'h67: begin e.op1 = pc; e.op2 = 4; e.ill = (f3 != 0); end
            'h63: begin
                e.rd = 0; e.brc = 1; e.op1 = a; e.op2 = b; e.op = brc_map[f3];
                e.ill = (f3 == 2 || f3 == 3);
            end
            'h03: begin e.ls = 1; e.op1 = a; e.op2 = imm_i; end
            'h23: begin e.rd = 0; e.ls = 1; e.op1 = a; e.op2 = imm_s; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.op = 0; e.op1 = 0; e.op2 = 0; e.brc = 0; e.ls = 0;
        end
        return e;
    endfunction

    // Compare DUT against the FIFO model (state after last edge)
    task automatic check_model();
        chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
        chk("s_ready", 32'(s_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("op_mode", 32'(m_op_mode), q[0].op);
            chk("op1", m_op1, q[0].op1);
            chk("op2", m_op2, q[0].op2);
            chk("pc", m_pc, q[0].pc);
            chk("rd", 32'(m_rd), q[0].rd);
            chk("is_brc", 32'(m_is_brc), 32'(q[0].brc));
            chk("is_ls", 32'(m_is_ls), 32'(q[0].ls));
            chk("illegal", 32'(m_illegal), 32'(q[0].ill));
        end
    endtask

    // One cycle: drive inputs, advance model, check at next negedge
    task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit mr, input bit fl);
        bit acc;
        bit drn;
        s_valid = v; s_inst = inst; s_pc = pc;
        s_rs1_v = a; s_rs2_v = b; m_ready = mr; flush = fl;
        acc = v && (q.size() < 2);
        drn = mr && (q.size() > 0);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(inst, pc, a, b));
        end
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [6:0] opcs[10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                                 7'h67, 7'h63, 7'h03, 7'h23, 7'h00};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        int s = $urandom_range(0, 3);
        w[6:0] = (k == 9) ? 7'($urandom) : opcs[k];
        if (s == 0) w[31:25] = 7'h00;
        else if (s == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_op1", m_op1, 32'd0);
        chk("rst_pc", m_pc, 32'd0);
        rst_n = 1'b1;

        step(1, 32'h002081B3, 32'h10, 32'd5, 32'd7, 1, 0);
        chk("add_valid", 32'(m_valid), 32'd1);
        chk("add_op", 32'(m_op_mode), 32'd0);
        chk("add_op1", m_op1, 32'd5);
        chk("add_op2", m_op2, 32'd7);
        chk("add_rd", 32'(m_rd), 32'd3);
        chk("add_ill", 32'(m_illegal), 32'd0);

        step(1, 32'h40405093, 32'h14, 32'h80000000, 32'd0, 1, 0);
        chk("srai_op", 32'(m_op_mode), 32'd13);
        chk("srai_op2", m_op2, 32'd4);
        step(1, 32'h02405093, 32'h18, 32'h80000000, 32'd0, 1, 0);
        chk("srai_f7_ill", 32'(m_illegal), 32'd1);
        chk("srai_f7_op1", m_op1, 32'd0);
        chk("srai_f7_op2", m_op2, 32'd0);

        step(1, 32'h0020F063, 32'h1C, 32'd1, 32'd2, 1, 0);
        chk("bgeu_op", 32'(m_op_mode), 32'd7);
        chk("bgeu_brc", 32'(m_is_brc), 32'd1);
        chk("bgeu_rd", 32'(m_rd), 32'd0);
        step(1, 32'h0020A063, 32'h20, 32'd1, 32'd2, 1, 0);
        chk("br_f3_2_ill", 32'(m_illegal), 32'd1);

        step(1, 32'h12345017, 32'h100, 32'd9, 32'd9, 1, 0);
        chk("auipc_op", 32'(m_op_mode), 32'd0);
        chk("auipc_op1", m_op1, 32'h100);
        chk("auipc_op2", m_op2, 32'h12345000);
        step(1, 32'h0000006F, 32'h200, 32'd9, 32'd9, 1, 0);
        chk("jal_op1", m_op1, 32'h200);
        chk("jal_op2", m_op2, 32'd4);
        step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);

        step(1, 32'h002081B3, 32'hA0, 32'd1, 32'd1, 0, 0);
        step(1, 32'h002081B3, 32'hB0, 32'd2, 32'd2, 0, 0);
        chk("bp_ready_after_b", 32'(s_ready), 32'd0);
        step(1, 32'h002081B3, 32'hC0, 32'd3, 32'd3, 0, 0);
        chk("bp_hold_a", m_pc, 32'hA0);
        step(1, 32'h002081B3, 32'hC0, 32'd3, 32'd3, 1, 0);
        chk("bp_out_b", m_pc, 32'hB0);
        step(1, 32'h002081B3, 32'hC0, 32'd3, 32'd3, 1, 0);
        chk("bp_out_c", m_pc, 32'hC0);
        chk("bp_c_valid", 32'(m_valid), 32'd1);
        step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);

        step(1, 32'h002081B3, 32'hD0, 32'd1, 32'd1, 0, 0);
        step(1, 32'h002081B3, 32'hD4, 32'd1, 32'd1, 0, 0);
        step(1, 32'h002081B3, 32'hD8, 32'd1, 32'd1, 0, 1);
        chk("flush_valid", 32'(m_valid), 32'd0);
        chk("flush_ready", 32'(s_ready), 32'd1);
        step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);
        chk("flush_stays_empty", 32'(m_valid), 32'd0);

        step(1, 32'h002081B3, 32'hE0, 32'd1, 32'd1, 0, 0);
        step(1, 32'h002081B3, 32'hE4, 32'd1, 32'd1, 0, 0);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_valid), 32'd0);
        chk("async_rst_ready", 32'(s_ready), 32'd1);
        q.delete();
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rnd_inst(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
